// File: rtl/wb_arb_pkg.sv
// Shared constants and state encoding for the 4-master Wishbone round-robin arbiter.
// Imported by the picker and the arbiter top.
package wb_arb_pkg;

   localparam int MASTER_COUNT = 4;
   localparam int WB_ADR_W     = 32;
   localparam int WB_DAT_W     = 32;
   localparam int WB_SEL_W     = 4;
   localparam int GRANT_W      = 2;
   localparam int CNT_W        = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_t;

   function automatic logic [GRANT_W-1:0] next_ptr(input logic [GRANT_W-1:0] g);
      return g + 2'd1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin search: returns the first set request bit at or above ptr,
// wrapping modulo MASTER_COUNT, plus a flag saying any request exists.
module rr_priority_picker
   import wb_arb_pkg::*;
(
   input  logic [MASTER_COUNT-1:0] req,
   input  logic [GRANT_W-1:0]      ptr,
   output logic [GRANT_W-1:0]      idx,
   output logic                    found
);

   // Walk from the farthest offset down so the nearest requester is assigned last.
   always_comb begin
      idx   = ptr;
      found = |req;
      for (int i = MASTER_COUNT - 1; i >= 0; i--) begin
         if (req[ptr + GRANT_W'(i)]) idx = ptr + GRANT_W'(i);
      end
   end

endmodule

// File: rtl/wb_rr_arbiter_4.sv
// Four-master Wishbone arbiter with round-robin grant, per-transfer stall timeout
// and a DRAIN state that swallows late slave acks after an abort.
module wb_rr_arbiter_4
   import wb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [MASTER_COUNT-1:0]          m_cyc_i,
   input  logic [MASTER_COUNT-1:0]          m_stb_i,
   input  logic [MASTER_COUNT-1:0]          m_we_i,
   input  logic [MASTER_COUNT*WB_SEL_W-1:0] m_sel_i,
   input  logic [MASTER_COUNT*WB_ADR_W-1:0] m_adr_i,
   input  logic [MASTER_COUNT*WB_DAT_W-1:0] m_dat_i,
   output logic [WB_DAT_W-1:0]              m_dat_o,
   output logic [MASTER_COUNT-1:0]          m_ack_o,
   output logic [MASTER_COUNT-1:0]          m_err_o,
   output logic [MASTER_COUNT-1:0]          m_int_o,
   output logic                             s_cyc_o,
   output logic                             s_stb_o,
   output logic                             s_we_o,
   output logic [WB_SEL_W-1:0]              s_sel_o,
   output logic [WB_ADR_W-1:0]              s_adr_o,
   output logic [WB_DAT_W-1:0]              s_dat_o,
   input  logic                             s_ack_i,
   input  logic                             s_int_i,
   input  logic [WB_DAT_W-1:0]              s_dat_i,
   output logic [GRANT_W-1:0]               grant_o,
   output logic                             grant_valid_o,
   output logic                             timeout_o,
   output arb_state_t                       state_dbg
);

   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   arb_state_t         state_q, state_d;
   logic [GRANT_W-1:0] grant_q, grant_d;
   logic [GRANT_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [GRANT_W-1:0] pick_idx;
   logic               pick_found;

   rr_priority_picker u_picker (
      .req   (m_cyc_i),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake: a slave beat completes in any BUSY cycle where s_stb_o and s_ack_i
   // are both high; s_ack_i with no strobe is forwarded but starts no beat.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_sel_o   = '0;
      s_adr_o   = '0;
      s_dat_o   = '0;
      m_ack_o   = '0;
      m_err_o   = '0;
      m_int_o   = '0;
      timeout_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            s_cyc_o = m_cyc_i[grant_q];
            s_stb_o = m_stb_i[grant_q];
            s_we_o  = m_we_i[grant_q];
            s_sel_o = m_sel_i[int'(grant_q)*WB_SEL_W +: WB_SEL_W];
            s_adr_o = m_adr_i[int'(grant_q)*WB_ADR_W +: WB_ADR_W];
            s_dat_o = m_dat_i[int'(grant_q)*WB_DAT_W +: WB_DAT_W];
            m_ack_o[grant_q] = s_ack_i;
            m_int_o[grant_q] = s_int_i;
            if (s_ack_i) cnt_d = '0;
            else if (m_stb_i[grant_q]) cnt_d = cnt_q + 1'b1;
            // An ack arriving on the limit cycle wins over the abort.
            if (!s_ack_i && cnt_q == TO_LIMIT) begin
               m_err_o[grant_q] = 1'b1;
               timeout_o        = 1'b1;
               state_d          = ST_DRAIN;
            end else if (!m_cyc_i[grant_q] && !s_ack_i) begin
               ptr_d   = next_ptr(grant_q);
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (!m_cyc_i[grant_q]) begin
               ptr_d   = next_ptr(grant_q);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A reset cycle abandons the transfer silently.
      if (rst) begin
         m_ack_o   = '0;
         m_err_o   = '0;
         m_int_o   = '0;
         timeout_o = 1'b0;
      end
   end

   assign m_dat_o       = s_dat_i;
   assign grant_o       = grant_q;
   assign grant_valid_o = (state_q != ST_IDLE);
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_wb_rr_arbiter_4.sv
// Self-checking bench for wb_rr_arbiter_4: directed transfers with a grant-order
// scoreboard plus timeout, ack race, reset and burst scenarios.
module tb_wb_rr_arbiter_4;
   import wb_arb_pkg::*;

   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   m_cyc_i, m_stb_i, m_we_i;
   logic [15:0]  m_sel_i;
   logic [127:0] m_adr_i, m_dat_i;
   logic [31:0]  m_dat_o;
   logic [3:0]   m_ack_o, m_err_o, m_int_o;
   logic         s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]   s_sel_o;
   logic [31:0]  s_adr_o, s_dat_o;
   logic         s_ack_i, s_int_i;
   logic [31:0]  s_dat_i;
   logic [1:0]   grant_o;
   logic         grant_valid_o, timeout_o;
   arb_state_t   state_dbg;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] adr_tbl[4];
   logic [31:0] dat_tbl[4];
   logic [3:0]  sel_tbl[4];
   logic [1:0]  exp_q[$];
   logic        gv_prev = 1'b0;

   wb_rr_arbiter_4 #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_int_o(m_int_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_ack_i(s_ack_i), .s_int_i(s_int_i), .s_dat_i(s_dat_i),
      .grant_o(grant_o), .grant_valid_o(grant_valid_o), .timeout_o(timeout_o),
      .state_dbg(state_dbg)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // scoreboard: every new ownership pops the next expected grant
   always @(negedge clk) begin
      if (grant_valid_o && !gv_prev) begin
         if (exp_q.size() == 0) check("sb_extra_grant", exp_q.size(), 1);
         else check("sb_grant", {30'd0, grant_o}, {30'd0, exp_q.pop_front()});
      end
      gv_prev <= grant_valid_o;
   end

   // driver tasks
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_master(input int n, input logic on);
      m_cyc_i[n] = on;
      m_stb_i[n] = on;
   endtask

   task automatic wait_grant();
      int i = 0;
      #1;
      while (!grant_valid_o && i < 8) begin
         next_cycle();
         #1;
         i++;
      end
      check("gv_wait", {31'd0, grant_valid_o}, 32'd1);
   endtask

   task automatic own_and_release(input int e, input int lat, input logic rearm);
      logic [3:0] oh;
      oh = 4'b0001 << e;
      wait_grant();
      check("s_adr", s_adr_o, adr_tbl[e]);
      check("s_cyc", {31'd0, s_cyc_o}, 32'd1);
      repeat (lat) begin
         next_cycle();
         #1;
      end
      s_ack_i = 1'b1;
      s_int_i = 1'b1;
      s_dat_i = $urandom;
      #1;
      check("m_ack", {28'd0, m_ack_o}, {28'd0, oh});
      check("m_int", {28'd0, m_int_o}, {28'd0, oh});
      check("m_dat", m_dat_o, s_dat_i);
      next_cycle();
      s_ack_i = 1'b0;
      s_int_i = 1'b0;
      set_master(e, 1'b0);
      next_cycle();
      if (rearm) set_master(e, 1'b1);
      #1;
      check("gv_release", {31'd0, grant_valid_o}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
      s_ack_i = 1'b0; s_int_i = 1'b0; s_dat_i = '0;
      for (int n = 0; n < 4; n++) begin
         adr_tbl[n] = $urandom;
         dat_tbl[n] = $urandom;
         sel_tbl[n] = 4'($urandom_range(1, 15));
         m_adr_i[32*n +: 32] = adr_tbl[n];
         m_dat_i[32*n +: 32] = dat_tbl[n];
         m_sel_i[4*n +: 4]   = sel_tbl[n];
         m_we_i[n]           = 1'($urandom_range(0, 1));
      end

      // reset state
      repeat (2) next_cycle();
      #1;
      check("rst_gv", {31'd0, grant_valid_o}, 32'd0);
      check("rst_grant", {30'd0, grant_o}, 32'd0);
      check("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
      check("rst_scyc", {31'd0, s_cyc_o}, 32'd0);
      check("rst_acks", {20'd0, m_ack_o, m_err_o, m_int_o}, 32'd0);
      check("rst_timeout", {31'd0, timeout_o}, 32'd0);
      rst = 1'b0;
      next_cycle();

      // single master 2, one-cycle arbitration latency, ack after 2 cycles
      exp_q.push_back(2'd2);
      set_master(2, 1'b1);
      #1;
      check("idle_gv", {31'd0, grant_valid_o}, 32'd0);
      check("idle_scyc", {31'd0, s_cyc_o}, 32'd0);
      next_cycle();
      #1;
      check("lat_grant", {30'd0, grant_o}, 32'd2);
      check("s_we", {31'd0, s_we_o}, {31'd0, m_we_i[2]});
      check("s_sel", {28'd0, s_sel_o}, {28'd0, sel_tbl[2]});
      check("s_dat", s_dat_o, dat_tbl[2]);
      own_and_release(2, 2, 1'b0);

      // pointer now 3: simultaneous 0 and 3 -> 3 first, then 0
      exp_q.push_back(2'd3);
      exp_q.push_back(2'd0);
      set_master(0, 1'b1);
      set_master(3, 1'b1);
      own_and_release(3, 0, 1'b0);
      own_and_release(0, 0, 1'b0);

      // reset mid-transfer of master 3
      exp_q.push_back(2'd3);
      set_master(3, 1'b1);
      wait_grant();
      check("pre_rst_grant", {30'd0, grant_o}, 32'd3);
      s_ack_i = 1'b1;
      rst = 1'b1;
      #1;
      check("rst_cycle_ack", {28'd0, m_ack_o}, 32'd0);
      check("rst_cycle_err", {28'd0, m_err_o}, 32'd0);
      next_cycle();
      rst = 1'b0;
      s_ack_i = 1'b0;
      set_master(0, 1'b1);
      #1;
      check("post_rst_scyc", {31'd0, s_cyc_o}, 32'd0);
      check("post_rst_gv", {31'd0, grant_valid_o}, 32'd0);
      check("post_rst_grant", {30'd0, grant_o}, 32'd0);
      check("post_rst_ack", {28'd0, m_ack_o}, 32'd0);
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd3);
      own_and_release(0, 1, 1'b0);
      own_and_release(3, 0, 1'b0);

      // full contention from pointer 0: order 0,1,2,3,0
      for (int n = 0; n < 4; n++) set_master(n, 1'b1);
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd3);
      exp_q.push_back(2'd0);
      own_and_release(0, 1, 1'b1);
      own_and_release(1, 0, 1'b0);
      own_and_release(2, 1, 1'b0);
      own_and_release(3, 0, 1'b0);
      own_and_release(0, 0, 1'b0);

      // burst: master 0 keeps cyc over 3 strobes while master 2 waits
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd2);
      set_master(0, 1'b1);
      wait_grant();
      set_master(2, 1'b1);
      for (int s = 0; s < 3; s++) begin
         s_ack_i = 1'b1;
         #1;
         check("burst_ack", {28'd0, m_ack_o}, 32'd1);
         check("burst_grant", {30'd0, grant_o}, 32'd0);
         next_cycle();
         s_ack_i = 1'b0;
         m_stb_i[0] = 1'b0;
         #1;
         check("burst_gap_stb", {31'd0, s_stb_o}, 32'd0);
         next_cycle();
         m_stb_i[0] = 1'b1;
      end
      set_master(0, 1'b0);
      #1;
      check("burst_no_preempt", {30'd0, grant_o}, 32'd0);
      next_cycle();
      #1;
      check("burst_idle", {31'd0, grant_valid_o}, 32'd0);
      own_and_release(2, 1, 1'b0);

      // timeout: master 1 stalls, error exactly TO cycles after strobe rises
      exp_q.push_back(2'd1);
      set_master(1, 1'b1);
      wait_grant();
      check("to_stb", {31'd0, s_stb_o}, 32'd1);
      for (int i = 1; i < TO; i++) begin
         next_cycle();
         #1;
         check("to_early", {27'd0, timeout_o, m_err_o}, 32'd0);
      end
      next_cycle();
      #1;
      check("to_err", {28'd0, m_err_o}, 32'd2);
      check("to_pulse", {31'd0, timeout_o}, 32'd1);
      next_cycle();
      #1;
      check("to_scyc_drop", {31'd0, s_cyc_o}, 32'd0);
      check("to_pulse_end", {27'd0, timeout_o, m_err_o}, 32'd0);
      check("to_drain", {30'd0, state_dbg}, {30'd0, ST_DRAIN});
      s_ack_i = 1'b1;
      #1;
      check("drain_ack_drop", {28'd0, m_ack_o}, 32'd0);
      next_cycle();
      s_ack_i = 1'b0;
      set_master(1, 1'b0);
      next_cycle();
      #1;
      check("drain_exit", {31'd0, grant_valid_o}, 32'd0);

      // race: ack on the limit cycle wins and clears the counter
      exp_q.push_back(2'd1);
      set_master(1, 1'b1);
      wait_grant();
      for (int i = 1; i < TO; i++) begin
         next_cycle();
         #1;
      end
      next_cycle();
      s_ack_i = 1'b1;
      #1;
      check("race_ack", {28'd0, m_ack_o}, 32'd2);
      check("race_no_err", {27'd0, timeout_o, m_err_o}, 32'd0);
      next_cycle();
      s_ack_i = 1'b0;
      #1;
      check("race_busy", {30'd0, state_dbg}, {30'd0, ST_BUSY});
      for (int i = 1; i < TO; i++) begin
         next_cycle();
         #1;
         check("race_cnt_clear", {31'd0, timeout_o}, 32'd0);
      end
      set_master(1, 1'b0);
      next_cycle();
      #1;
      check("race_release", {31'd0, grant_valid_o}, 32'd0);

      repeat (2) next_cycle();
      check("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/wb_rr_arbiter_4.md
WB_RR_ARBITER_4 -- requirements
Module: wb_rr_arbiter_4

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: stalled cycles (stb high, no ack) before abort; legal range 1..65535.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 m_cyc_i  input  4  per-master cycle request, bit n = master n.
REQ-005 m_stb_i  input  4  per-master strobe.
REQ-006 m_we_i  input  4  per-master write enable.
REQ-007 m_sel_i  input  16  byte selects, master n at [4n+3:4n].
REQ-008 m_adr_i  input  128  addresses, master n at [32n+31:32n].
REQ-009 m_dat_i  input  128  write data, master n at [32n+31:32n].
REQ-010 m_dat_o  output  32  read data, s_dat_i broadcast to all masters.
REQ-011 m_ack_o  output  4  per-master ack.
REQ-012 m_err_o  output  4  per-master timeout error, one-cycle pulse.
REQ-013 m_int_o  output  4  per-master interrupt.
REQ-014 s_cyc_o, s_stb_o, s_we_o  output  1 each  slave control.
REQ-015 s_sel_o  output  4; s_adr_o  output  32; s_dat_o  output  32  slave payload.
REQ-016 s_ack_i  input  1; s_int_i  input  1; s_dat_i  input  32  slave returns.
REQ-017 grant_o  output  2  index of current owner; grant_valid_o  output  1  owner present.
REQ-018 timeout_o  output  1  one-cycle pulse on each abort.

Function
REQ-019 States: IDLE, BUSY, DRAIN; the state register shall be the only source of grant_valid_o (high in BUSY and DRAIN).
REQ-020 IDLE: if any m_cyc_i bit is high, the block shall register grant_o as the first requester found searching upward from rr_ptr modulo 4, and enter BUSY next cycle; no slave signal is driven in the IDLE cycle (1-cycle arbitration latency).
REQ-021 BUSY: s_cyc/stb/we/sel/adr/dat shall equal the granted master's inputs combinationally; m_ack_o[grant] = s_ack_i; m_int_o[grant] = s_int_i; all other ack/int bits 0.
REQ-022 Outside BUSY all s_* outputs and all m_ack_o/m_int_o bits shall be 0.
REQ-023 Release: in BUSY, when m_cyc_i[grant]=0 and s_ack_i=0, go to IDLE and set rr_ptr = (grant+1) mod 4.
REQ-024 Timeout counter (16 bits): cleared on entering BUSY and on every s_ack_i; increments each BUSY cycle with s_stb_o=1 and s_ack_i=0; holds otherwise.
REQ-025 When the counter equals TIMEOUT_CYCLES in BUSY without s_ack_i, the block shall pulse m_err_o[grant] and timeout_o for that cycle and enter DRAIN.
REQ-026 s_ack_i in the same cycle the counter reaches TIMEOUT_CYCLES shall win: ack forwarded, no error, counter cleared.
REQ-027 DRAIN: wait until m_cyc_i[grant]=0, then IDLE with rr_ptr = (grant+1) mod 4; late s_ack_i in DRAIN shall be discarded.
REQ-028 Requests from non-granted masters shall not preempt; they wait, and each requester is granted within 3 ownerships of the others (round-robin fairness).
REQ-029 Simultaneous requests in IDLE: the nearest index at or above rr_ptr wins.

Reset
REQ-030 On rst: state IDLE, rr_ptr 0, grant_o 0, grant_valid_o 0, counter 0, timeout_o 0, all m_ack_o/m_err_o/m_int_o 0, all s_* outputs 0.
REQ-031 rst asserted mid-transfer shall abandon the transfer with no ack or error pulse; the slave sees s_cyc_o drop on the cycle after rst is sampled.

Structure
REQ-032 Shared package wb_arb_pkg holds MASTER_COUNT=4, WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4 and the state enumeration.
REQ-033 One combinational sub-module rr_priority_picker (4-bit request, 2-bit pointer in; 2-bit index plus found flag out) performs the search.

Verification
REQ-034 Single master: m_cyc_i=4'b0100, stb, slave acks after 2 cycles -> grant_o=2 one cycle after request, m_ack_o=4'b0100, rr_ptr becomes 3.
REQ-035 Contention: m_cyc_i=4'b1111 held, each master releases after one ack -> grant order 0,1,2,3,0.
REQ-036 Timeout: TIMEOUT_CYCLES=4, master 1 strobes, slave never acks -> m_err_o=4'b0010 and timeout_o pulse exactly 4 stalled cycles after s_stb_o rises, s_cyc_o=0 next cycle.
REQ-037 Race: TIMEOUT_CYCLES=4, s_ack_i on the 4th stalled cycle -> m_ack_o pulses, m_err_o stays 0.
REQ-038 Reset mid-cycle: rst asserted during master 3 BUSY -> all outputs 0 next cycle, next grant with m_cyc_i=4'b1001 goes to master 0.
REQ-039 Burst: master 0 holds cyc across 3 strobes, master 2 requesting -> no preemption; master 2 granted only after master 0 drops cyc.
